// File: rtl/uart_alu_sequencer_pkg.sv
// Shared definitions for the UART/ALU sequencer: widths, FSM state encodings and ALU opcodes.
// The opcode constants are also used by the ALU and by the benches.
package uart_alu_sequencer_pkg;

  localparam int unsigned WIDTH_WORD_DEF   = 8;
  localparam int unsigned WIDTH_OPCODE_DEF = 6;

  typedef enum logic [5:0] {
    ST_WAIT_A  = 6'b000001,
    ST_WAIT_B  = 6'b000010,
    ST_WAIT_OP = 6'b000100,
    ST_EXEC    = 6'b001000,
    ST_SEND    = 6'b010000,
    ST_WAIT_TX = 6'b100000
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/uart_alu_sequencer_rise_detect.sv
// Rising-edge detector: turns a level held for any number of cycles into a single event.
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) level_q <= 1'b0;
    else         level_q <= level_i;
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, runs them through the
// external ALU and hands the result to the transmitter; recovers from lost bytes via a timeout.
module uart_alu_sequencer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH_WORD     = WIDTH_WORD_DEF,
  parameter int unsigned WIDTH_OPCODE   = WIDTH_OPCODE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_rx_done,
  input  logic [WIDTH_WORD-1:0]   i_rx_data,
  input  logic                    i_tx_done,
  input  logic [WIDTH_WORD-1:0]   i_alu_result,
  output logic [WIDTH_WORD-1:0]   o_alu_a,
  output logic [WIDTH_WORD-1:0]   o_alu_b,
  output logic [WIDTH_OPCODE-1:0] o_alu_opcode,
  output logic                    o_tx_start,
  output logic [WIDTH_WORD-1:0]   o_tx_data,
  output logic                    o_busy,
  output logic                    o_timeout,
  output logic                    o_overrun
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH_WORD-1:0]   alu_a_q, alu_b_q, tx_data_q;
  logic [WIDTH_OPCODE-1:0] opcode_q;
  logic                    tx_start_q, timeout_q, overrun_q;
  logic                    rx_evt, tx_evt;

  rise_detect u_rx_rise (.clk_i(i_clock), .rst_ni(i_reset), .level_i(i_rx_done), .rise_o(rx_evt));
  rise_detect u_tx_rise (.clk_i(i_clock), .rst_ni(i_reset), .level_i(i_tx_done), .rise_o(tx_evt));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_WAIT_A;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      case (state_q)
        ST_WAIT_A: if (rx_evt) begin
          alu_a_q <= i_rx_data;
          cnt_q   <= '0;
          state_q <= ST_WAIT_B;
        end
        ST_WAIT_B: if (rx_evt) begin
          alu_b_q <= i_rx_data;
          cnt_q   <= '0;
          state_q <= ST_WAIT_OP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_WAIT_A;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        ST_WAIT_OP: if (rx_evt) begin
          opcode_q <= i_rx_data[WIDTH_OPCODE-1:0];
          cnt_q    <= '0;
          state_q  <= ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          timeout_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_WAIT_A;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        // Start is raised here so the registered pulse coincides with the SEND cycle.
        ST_EXEC: begin
          tx_data_q  <= i_alu_result;
          tx_start_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND:    state_q <= ST_WAIT_TX;
        ST_WAIT_TX: if (tx_evt) state_q <= ST_WAIT_A;
        default:    state_q <= ST_WAIT_A;
      endcase
      if (rx_evt && (state_q inside {ST_EXEC, ST_SEND, ST_WAIT_TX}))
        overrun_q <= 1'b1;
    end
  end

  assign o_alu_a      = alu_a_q;
  assign o_alu_b      = alu_b_q;
  assign o_alu_opcode = opcode_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_timeout    = timeout_q;
  assign o_overrun    = overrun_q;
  // One-hot bit 0 is WAIT_A, so busy comes straight off a single flop.
  assign o_busy       = ~state_q[0];

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: directed scenarios plus randomized frames checked
// against a frame-level reference model and an ALU model driving i_alu_result.
module tb_uart_alu_sequencer;
  import uart_alu_sequencer_pkg::*;

  // Timeout long enough that bytes held 16 cycles still arrive inside the inter-byte window.
  localparam int TO = 20;

  logic       i_clock = 1'b0, i_reset = 1'b0, i_rx_done = 1'b0, i_tx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00, i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_opcode;
  logic       o_tx_start, o_busy, o_timeout, o_overrun;

  uart_alu_sequencer #(.WIDTH_WORD(8), .WIDTH_OPCODE(6), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .i_tx_done(i_tx_done), .i_alu_result(i_alu_result), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_opcode(o_alu_opcode), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_overrun(o_overrun));

  always #5 i_clock = ~i_clock;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return 8'($signed(a) >>> b[2:0]);
      OP_SRL:  return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_opcode);

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_start = 0, n_timeout = 0, n_overrun = 0, start_cyc = 0, timeout_cyc = 0;
  logic prev_start = 1'b0;

  always @(posedge i_clock) cyc++;

  // Event monitor, sampled on the falling edge.
  always @(negedge i_clock) begin
    if (o_tx_start) begin
      n_start++;
      start_cyc = cyc;
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_width: o_tx_start high %0d consecutive cycles, required 1", 2);
      end
    end
    if (o_timeout) begin
      n_timeout++;
      timeout_cyc = cyc;
    end
    if (o_overrun) n_overrun++;
    prev_start = o_tx_start;
  end

  task automatic nclk();
    @(negedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int hold, output int evt);
    nclk();
    i_rx_done = 1'b1;
    i_rx_data = d;
    evt = cyc;
    repeat (hold) nclk();
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  // Sends a full frame and checks capture, result, latency, busy, optional overrun and early tx_done.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op_byte, input int hold_rx, input int hold_tx,
                           input int gap, input bit ovr, input bit early_tx);
    int e, e_op, s0, o0;
    logic [7:0] exp_res;
    s0 = n_start;
    exp_res = alu_ref(a, b, op_byte[5:0]);
    send_byte(a, hold_rx, e);
    repeat (gap) nclk();
    if (early_tx) begin
      nclk(); i_tx_done = 1'b1; nclk(); i_tx_done = 1'b0;
    end
    send_byte(b, hold_rx, e);
    repeat (gap) nclk();
    send_byte(op_byte, hold_rx, e_op);
    for (int i = 0; i < 40 && n_start == s0; i++) nclk();
    checks++;
    if (n_start !== s0 + 1) begin
      errors++;
      $display("FAIL %s start_count: got %0d required %0d", tag, n_start - s0, 1);
    end
    checks++;
    if (start_cyc - e_op !== 2) begin
      errors++;
      $display("FAIL %s latency: got %0d required 2", tag, start_cyc - e_op);
    end
    checks++;
    if ({o_alu_a, o_alu_b, o_alu_opcode} !== {a, b, op_byte[5:0]}) begin
      errors++;
      $display("FAIL %s operands: got %h %h %h required %h %h %h", tag, o_alu_a, o_alu_b,
               o_alu_opcode, a, b, op_byte[5:0]);
    end
    checks++;
    if (o_tx_data !== exp_res) begin
      errors++;
      $display("FAIL %s tx_data: got %h required %h", tag, o_tx_data, exp_res);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_before_tx: got %b required 1", tag, o_busy);
    end
    if (ovr) begin
      o0 = n_overrun;
      send_byte(8'hAA, hold_rx, e);
      repeat (2) nclk();
      checks++;
      if (n_overrun !== o0 + 1 || o_tx_data !== exp_res || o_busy !== 1'b1 || o_alu_a !== a) begin
        errors++;
        $display("FAIL %s overrun: pulses %0d tx %h busy %b a %h required 1 %h 1 %h", tag,
                 n_overrun - o0, o_tx_data, o_busy, o_alu_a, exp_res, a);
      end
    end
    nclk();
    i_tx_done = 1'b1;
    nclk();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_tx: got %b required 0", tag, o_busy);
    end
    repeat (hold_tx - 1) nclk();
    i_tx_done = 1'b0;
    repeat (3) nclk();
    checks++;
    if (n_start !== s0 + 1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state: starts %0d busy %b required 1 0", tag, n_start - s0, o_busy);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) nclk();
    checks++;
    if ({o_alu_a, o_alu_b, o_alu_opcode, o_tx_data, o_tx_start, o_busy, o_timeout, o_overrun}
        !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h %h %h %h %b%b%b%b required all 0", o_alu_a, o_alu_b,
               o_alu_opcode, o_tx_data, o_tx_start, o_busy, o_timeout, o_overrun);
    end
    i_reset = 1'b1;
    nclk();
  endtask

  task automatic test_basic_frame();
    run_frame("basic", 8'h05, 8'h03, 8'h20, 1, 1, 0, 1'b0, 1'b0);
    checks++;
    if (o_tx_data !== 8'h08) begin
      errors++;
      $display("FAIL basic_sum: got %h required %h", o_tx_data, 8'h08);
    end
  endtask

  task automatic test_held_levels();
    run_frame("held", 8'h9C, 8'h0F, {2'b11, OP_AND}, 16, 16, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int e, s;
    s = n_timeout;
    send_byte(8'h11, 1, e);
    for (int i = 0; i < TO + 10 && n_timeout == s; i++) nclk();
    repeat (3) nclk();
    checks++;
    if (n_timeout !== s + 1) begin
      errors++;
      $display("FAIL timeout_count: got %0d required 1", n_timeout - s);
    end
    // Capture edge is one cycle after the event cycle; timeout fires TO cycles after capture.
    checks++;
    if (timeout_cyc - e !== TO + 1) begin
      errors++;
      $display("FAIL timeout_time: got %0d required %0d", timeout_cyc - e, TO + 1);
    end
    checks++;
    if (o_busy !== 1'b0 || o_alu_a !== 8'h11) begin
      errors++;
      $display("FAIL timeout_state: busy %b a %h required 0 11", o_busy, o_alu_a);
    end
    run_frame("after_timeout", 8'h07, 8'h02, 8'h22, 1, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_coincidence();
    int ea, s0, t0;
    t0 = n_timeout;
    s0 = n_start;
    send_byte(8'h44, 1, ea);
    // Counter reaches TO-1 during the cycle numbered ea+TO; B's rising edge lands exactly there.
    while (cyc < ea + TO) nclk();
    i_rx_done = 1'b1;
    i_rx_data = 8'h21;
    nclk();
    i_rx_done = 1'b0;
    repeat (2) nclk();
    checks++;
    if (n_timeout !== t0 || o_busy !== 1'b1 || o_alu_b !== 8'h21) begin
      errors++;
      $display("FAIL coincidence: timeouts %0d busy %b b %h required 0 1 21", n_timeout - t0,
               o_busy, o_alu_b);
    end
    send_byte({2'b00, OP_XOR}, 1, ea);
    repeat (4) nclk();
    checks++;
    if (n_start !== s0 + 1 || o_tx_data !== 8'h65) begin
      errors++;
      $display("FAIL coincidence_frame: starts %0d tx %h required 1 65", n_start - s0, o_tx_data);
    end
    nclk(); i_tx_done = 1'b1; nclk(); i_tx_done = 1'b0; nclk();
  endtask

  task automatic test_overrun();
    run_frame("overrun", 8'h30, 8'h0C, 8'h22, 1, 2, 1, 1'b1, 1'b0);
    run_frame("post_overrun", 8'h0F, 8'hF0, {2'b01, OP_OR}, 2, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_early_tx();
    run_frame("early_tx", 8'hF0, 8'h04, {2'b10, OP_SRA}, 1, 1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int e, s0, t0;
    send_byte(8'h5A, 1, e);
    send_byte(8'hC3, 1, e);
    nclk();
    #2;
    i_reset = 1'b0;
    #1;
    checks++;
    if ({o_alu_a, o_alu_b, o_alu_opcode, o_tx_data, o_tx_start, o_busy, o_timeout, o_overrun}
        !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h %h %h %h %b%b%b%b required all 0", o_alu_a, o_alu_b,
               o_alu_opcode, o_tx_data, o_tx_start, o_busy, o_timeout, o_overrun);
    end
    repeat (2) nclk();
    i_reset = 1'b1;
    s0 = n_start;
    t0 = n_timeout;
    send_byte(8'h20, 1, e);
    repeat (TO + 10) nclk();
    checks++;
    if (n_start !== s0 || n_timeout !== t0 + 1 || o_alu_a !== 8'h20) begin
      errors++;
      $display("FAIL reset_no_start: starts %0d timeouts %0d a %h required 0 1 20",
               n_start - s0, n_timeout - t0, o_alu_a);
    end
    run_frame("after_reset", 8'h81, 8'h02, {2'b00, OP_SRL}, 1, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
    for (int i = 0; i < 12; i++) begin
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      run_frame($sformatf("rand%0d", i), 8'($urandom), 8'($urandom),
                {2'($urandom), op}, $urandom_range(1, 4), $urandom_range(1, 6),
                $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_held_levels();
    test_timeout();
    test_coincidence();
    test_overrun();
    test_early_tx();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
